// File: rtl/z_pkg.sv
// Shared types and constants for the z tile sequencer: sample/tag layouts and FSM states.
package z_pkg;

    localparam int Z_W       = 27;
    localparam int TILE_LOG2 = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } zseq_state_e;

    typedef struct packed {
        logic [Z_W-1:0]       z;
        logic [TILE_LOG2-1:0] x;
        logic [TILE_LOG2-1:0] y;
        logic                 last;
    } zsample_t;

    typedef struct packed {
        logic [TILE_LOG2-1:0] x;
        logic [TILE_LOG2-1:0] y;
        logic                 last;
    } ztag_t;

endpackage

// File: rtl/z_out_fifo.sv
// Output FIFO of z samples. The count reflects registered occupancy; push and pop may coincide.
module z_out_fifo
    import z_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  zsample_t         push_data,
    input  logic             pop,
    output zsample_t         head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    zsample_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // Head is forced to zero when empty so stale storage never shows on the outputs.
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/z_tile_sequencer.sv
// Walks one screen tile per command through a fixed-latency z interpolator and
// buffers tagged results in a credit-managed output FIFO.
module z_tile_sequencer
    import z_pkg::*;
#(
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [Z_W-1:0]       cmd_dzdx,
    input  logic [Z_W-1:0]       cmd_dzdy,
    input  logic [Z_W-1:0]       cmd_c,
    output logic [TILE_LOG2-1:0] interp_x,
    output logic [TILE_LOG2-1:0] interp_y,
    output logic [Z_W-1:0]       interp_dzdx,
    output logic [Z_W-1:0]       interp_dzdy,
    output logic [Z_W-1:0]       interp_c,
    input  logic [Z_W-1:0]       interp_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Z_W-1:0]       out_z,
    output logic [TILE_LOG2-1:0] out_x,
    output logic [TILE_LOG2-1:0] out_y,
    output logic                 out_last,
    output logic                 busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(LAT + 1);

    zseq_state_e          state_q, state_d;
    logic [TILE_LOG2-1:0] x_q, x_d, y_q, y_d;
    logic [Z_W-1:0]       dzdx_q, dzdx_d, dzdy_q, dzdy_d, c_q, c_d;
    logic [LAT-1:0]       vld_q, vld_d;
    ztag_t                tag_q [LAT];
    ztag_t                tag_d [LAT];
    logic [INF_W-1:0]     inflight_q, inflight_d;

    logic             issue, push, pop, credit, last_now;
    logic [CNT_W-1:0] fifo_count;
    zsample_t         head;

    assign last_now = (&x_q) && (&y_q);
    assign push     = vld_q[LAT-1];
    assign pop      = out_valid && out_ready;
    // A same-cycle pop already frees its slot, so it counts toward credit immediately.
    assign credit   = (int'(fifo_count) - int'(pop) + int'(inflight_q)) < FIFO_DEPTH;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dzdx_d    = dzdx_q;
        dzdy_d    = dzdy_q;
        c_d       = c_q;
        cmd_ready = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    dzdx_d  = cmd_dzdx;
                    dzdy_d  = cmd_dzdy;
                    c_d     = cmd_c;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (credit) begin
                    issue = 1'b1;
                    x_d   = x_q + 1'b1;
                    if (&x_q) y_d = y_q + 1'b1;
                    if (last_now) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_d[0] = issue;
        tag_d[0] = '{x: x_q, y: y_q, last: last_now};
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
        inflight_d = inflight_q + INF_W'(issue) - INF_W'(push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            dzdx_q     <= '0;
            dzdy_q     <= '0;
            c_q        <= '0;
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dzdx_q     <= dzdx_d;
            dzdy_q     <= dzdy_d;
            c_q        <= c_d;
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    // Tag pipe exit lines up with interp_z for the same sample.
    z_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ('{z: interp_z, x: tag_q[LAT-1].x, y: tag_q[LAT-1].y, last: tag_q[LAT-1].last}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign interp_x    = x_q;
    assign interp_y    = y_q;
    assign interp_dzdx = dzdx_q;
    assign interp_dzdy = dzdy_q;
    assign interp_c    = c_q;
    assign out_valid   = (fifo_count != '0);
    assign out_z       = head.z;
    assign out_x       = head.x;
    assign out_y       = head.y;
    assign out_last    = head.last;
    assign busy        = (state_q != IDLE) || out_valid;

endmodule

// File: tb/tb_z_tile_sequencer.sv
// Scoreboard bench for z_tile_sequencer with a behavioural fixed-latency interpolator.
module tb_z_tile_sequencer;
    import z_pkg::*;

    localparam int TB_LAT = 4;

    logic                 clk, rst;
    logic                 cmd_valid, cmd_ready;
    logic [Z_W-1:0]       cmd_dzdx, cmd_dzdy, cmd_c;
    logic [TILE_LOG2-1:0] interp_x, interp_y;
    logic [Z_W-1:0]       interp_dzdx, interp_dzdy, interp_c, interp_z;
    logic                 out_valid, out_ready;
    logic [Z_W-1:0]       out_z;
    logic [TILE_LOG2-1:0] out_x, out_y;
    logic                 out_last, busy;

    int       n_cmp = 0;
    int       n_err = 0;
    int       rdy_mode = 0;
    zsample_t exp_q[$];
    zsample_t got_q[$];
    logic [Z_W-1:0] zp [TB_LAT];

    z_tile_sequencer #(.LAT(TB_LAT), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dzdx(cmd_dzdx), .cmd_dzdy(cmd_dzdy), .cmd_c(cmd_c),
        .interp_x(interp_x), .interp_y(interp_y),
        .interp_dzdx(interp_dzdx), .interp_dzdy(interp_dzdy), .interp_c(interp_c),
        .interp_z(interp_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_x(out_x), .out_y(out_y), .out_last(out_last),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Interpolator model: result for the inputs seen TB_LAT cycles earlier.
    always @(posedge clk) begin
        zp[0] <= interp_c + interp_dzdx * Z_W'(interp_x) + interp_dzdy * Z_W'(interp_y);
        for (int i = 1; i < TB_LAT; i++) zp[i] <= zp[i-1];
    end
    assign interp_z = zp[TB_LAT-1];

    // out_ready pattern: 0 always high, 1 alternating, 2 random, 3 held low.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tile(input logic [Z_W-1:0] c, input logic [Z_W-1:0] dx, input logic [Z_W-1:0] dy);
        zsample_t e;
        for (int yy = 0; yy < 32; yy++) begin
            for (int xx = 0; xx < 32; xx++) begin
                e.z    = c + dx * Z_W'(xx) + dy * Z_W'(yy);
                e.x    = TILE_LOG2'(xx);
                e.y    = TILE_LOG2'(yy);
                e.last = (xx == 31) && (yy == 31);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_cmd(input logic [Z_W-1:0] c, input logic [Z_W-1:0] dx, input logic [Z_W-1:0] dy,
                            output int waited, output logic ov_at_acc);
        cmd_valid = 1'b1;
        cmd_c     = c;
        cmd_dzdx  = dx;
        cmd_dzdy  = dy;
        waited    = 0;
        while (!cmd_ready && waited < 5000) begin
            tick();
            waited++;
        end
        if (waited >= 5000) chk("cmd_accept_timeout", 64'(waited), 64'(0));
        ov_at_acc = out_valid;
        push_tile(c, dx, dy);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < budget) begin
            tick();
            i++;
        end
        chk("drain_timeout", 64'(i < budget), 64'(1));
    endtask

    initial begin
        int   waited, lat, gaps, guard, cnt;
        logic ov;
        zsample_t got, e;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_c = '0;
        cmd_dzdx = '0;
        cmd_dzdy = '0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    got = '{z: out_z, x: out_x, y: out_y, last: out_last};
                    got_q.push_back(got);
                    if (exp_q.size() == 0) begin
                        chk("spurious_beat", 64'(got), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 64'(got), 64'(e));
                    end
                end
            end
        join_none

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_interp", {interp_x, interp_y, interp_dzdx[15:0], interp_dzdy[15:0], interp_c[15:0]}, 64'(0));
        chk("rst_out", 64'({out_z, out_x, out_y, out_last}), 64'(0));
        rst = 1'b0;
        tick();

        // Throughput: z = 32*y + x
        rdy_mode = 0;
        got_q.delete();
        send_cmd(27'd0, 27'd1, 27'd32, waited, ov);
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("first_latency", 64'(lat), 64'(6));
        gaps = 0;
        for (int i = 0; i < 1024; i++) begin
            if (!out_valid) gaps++;
            tick();
        end
        chk("throughput_gaps", 64'(gaps), 64'(0));
        wait_idle(200);
        chk("tp_count", 64'(got_q.size()), 64'(1024));
        if (got_q.size() == 1024) begin
            chk("tp_z37", 64'(got_q[37].z), 64'(37));
            chk("tp_z1023", 64'({got_q[1023].z, got_q[1023].last}), 64'({27'd1023, 1'b1}));
            chk("tp_last_1022", 64'(got_q[1022].last), 64'(0));
        end

        // Backpressure
        got_q.delete();
        send_cmd(27'd7, 27'd3, 27'd100, waited, ov);
        guard = 0;
        while (got_q.size() < 200 && guard < 2000) begin
            tick();
            guard++;
        end
        rdy_mode = 3;
        repeat (100) tick();
        chk("stall_out_valid", 64'(out_valid), 64'(1));
        chk("stall_issue_index", 64'({interp_y, interp_x}), 64'(got_q.size() + 8));
        cnt = got_q.size();
        repeat (10) tick();
        chk("stall_no_pop", 64'(got_q.size()), 64'(cnt));
        rdy_mode = 2;
        wait_idle(6000);
        rdy_mode = 0;
        chk("bp_count", 64'(got_q.size()), 64'(1024));

        // Back-to-back tiles with alternating downstream readiness
        got_q.delete();
        rdy_mode = 1;
        send_cmd(27'd100, 27'd1, 27'd32, waited, ov);
        send_cmd(27'd5000, 27'd2, 27'h7FFFFFF, waited, ov);
        chk("b2b_cmd_ready_low", 64'(waited >= 1024), 64'(1));
        chk("b2b_fifo_nonempty_at_accept", 64'(ov), 64'(1));
        rdy_mode = 0;
        wait_idle(4000);
        chk("b2b_count", 64'(got_q.size()), 64'(2048));
        if (got_q.size() == 2048) begin
            chk("b2b_a_last", 64'({got_q[1023].z, got_q[1023].last}), 64'({27'd1123, 1'b1}));
            chk("b2b_b_first", 64'(got_q[1024].z), 64'(5000));
            chk("b2b_b_second", 64'(got_q[1025].z), 64'(5002));
        end

        // Modulo wrap
        got_q.delete();
        send_cmd(27'h7FFFFFF, 27'd1, 27'd0, waited, ov);
        wait_idle(2000);
        if (got_q.size() >= 3) begin
            chk("wrap_z0", 64'(got_q[0].z), 64'(27'h7FFFFFF));
            chk("wrap_z1", 64'(got_q[1].z), 64'(0));
            chk("wrap_z2", 64'(got_q[2].z), 64'(1));
        end else begin
            chk("wrap_count", 64'(got_q.size()), 64'(1024));
        end

        // Reset mid-RUN
        got_q.delete();
        send_cmd(27'd11, 27'd5, 27'd9, waited, ov);
        guard = 0;
        while (got_q.size() < 300 && guard < 2000) begin
            tick();
            guard++;
        end
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("midrst_busy", 64'(busy), 64'(0));
        cnt = 0;
        repeat (10) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("midrst_quiet", 64'(cnt), 64'(0));

        // Negative gradients after the reset
        got_q.delete();
        send_cmd(27'd4096, 27'h7FFFFFE, 27'h7FFFFC0, waited, ov);
        wait_idle(2000);
        chk("neg_count", 64'(got_q.size()), 64'(1024));
        if (got_q.size() == 1024) begin
            chk("neg_z_last", 64'({got_q[1023].z, got_q[1023].last}), 64'({27'd2050, 1'b1}));
            chk("neg_z_first", 64'(got_q[0].z), 64'(4096));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
